// File: rtl/can_crc_checker.sv
// rtl/can_crc_checker.sv - receive-side CAN CRC-15 checker with delimiter and optional stuff check
//
// Consumes the sampled serial bit stream of one CAN frame. It runs a CRC-15
// over the protected field (SOF through data), captures the 15 transmitted
// CRC bits, samples the CRC delimiter and reports a one-cycle verdict.
//
// Build option: CAN_CRC_CHK_STUFF_EN
//   defined   - in-line destuffing of DATA and CRC bits, stuff_err reported
//   undefined - input already destuffed, stuff_err tied low
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   frame_start  1-cycle pulse, begin frame and sample data_len
//   data_len     number of CRC-protected bits, valid 1..MAX_BITS
//   bit_valid    1-cycle strobe, rx_bit holds a sampled bit
//   rx_bit       received bit (1 = recessive)
//   abort        drop current frame, back to IDLE
//   busy         high in any state other than IDLE
//   crc_ok       1-cycle pulse, received CRC equals computed CRC
//   crc_err      1-cycle pulse, CRC mismatch
//   form_err     1-cycle pulse, CRC delimiter sampled dominant
//   stuff_err    1-cycle pulse, stuff rule violated
//   calc_crc     computed CRC, frozen at end of DATA
//   rx_crc       received CRC field, MSB first
module can_crc_checker #(
    parameter logic [14:0] POLY     = 15'h4599,
    parameter int          MAX_BITS = 83
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [6:0]  data_len,
    input  logic        bit_valid,
    input  logic        rx_bit,
    input  logic        abort,
    output logic        busy,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        form_err,
    output logic        stuff_err,
    output logic [14:0] calc_crc,
    output logic [14:0] rx_crc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_CRC   = 3'd2;
    localparam logic [2:0] S_DELIM = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [6:0] MAX_LEN = 7'(MAX_BITS);

    logic [2:0] state;
    logic [6:0] bit_cnt;

    logic start_ok;
    logic take_bit;
    logic data_bit;
    logic stuff_fail;
    logic crc_nxt;

    // Out-of-range lengths never start a frame, so they also never pre-empt
    // a bit in the same cycle.
    assign start_ok = frame_start && (data_len != 7'd0) && (data_len <= MAX_LEN);
    assign take_bit = bit_valid && !abort && !start_ok &&
                      ((state == S_DATA) || (state == S_CRC));
    assign crc_nxt  = rx_bit ^ calc_crc[14];
    assign busy     = (state != S_IDLE);

`ifdef CAN_CRC_CHK_STUFF_EN
    logic [2:0] run_len;
    logic       run_bit;
    logic       stuff_slot;

    // After five equal bits the next strobe is a stuff bit, not payload.
    assign stuff_slot = (run_len == 3'd5);
    assign stuff_fail = take_bit && stuff_slot && (rx_bit == run_bit);
    assign data_bit   = take_bit && !stuff_slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len   <= 3'd0;
            run_bit   <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            stuff_err <= stuff_fail;
            if (abort) begin
                run_len <= run_len;
            end else if (start_ok) begin
                run_len <= 3'd0;
            end else if (take_bit) begin
                // A valid stuff bit opens a new run; the run otherwise spans
                // DATA and CRC continuously.
                if (stuff_slot || (run_len == 3'd0) || (rx_bit != run_bit)) begin
                    run_len <= 3'd1;
                    run_bit <= rx_bit;
                end else begin
                    run_len <= run_len + 3'd1;
                end
            end
        end
    end
`else
    assign stuff_fail = 1'b0;
    assign data_bit   = take_bit;
    assign stuff_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            bit_cnt  <= 7'd0;
            calc_crc <= 15'd0;
            rx_crc   <= 15'd0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            form_err <= 1'b0;
        end else begin
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            form_err <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else if (start_ok) begin
                state    <= S_DATA;
                bit_cnt  <= data_len;
                calc_crc <= 15'd0;
                rx_crc   <= 15'd0;
            end else if (stuff_fail) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_DATA: begin
                        if (data_bit) begin
                            calc_crc <= {calc_crc[13:0], 1'b0} ^ (crc_nxt ? POLY : 15'd0);
                            if (bit_cnt == 7'd1) begin
                                bit_cnt <= 7'd15;
                                state   <= S_CRC;
                            end else begin
                                bit_cnt <= bit_cnt - 7'd1;
                            end
                        end
                    end
                    S_CRC: begin
                        if (data_bit) begin
                            rx_crc <= {rx_crc[13:0], rx_bit};
                            if (bit_cnt == 7'd1) begin
                                bit_cnt <= 7'd0;
                                state   <= S_DELIM;
                            end else begin
                                bit_cnt <= bit_cnt - 7'd1;
                            end
                        end
                    end
                    S_DELIM: begin
                        // Verdict is registered here so it is visible during DONE.
                        if (bit_valid) begin
                            form_err <= ~rx_bit;
                            crc_ok   <= (rx_crc == calc_crc);
                            crc_err  <= (rx_crc != calc_crc);
                            state    <= S_DONE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_crc_checker.sv
// tb/tb_can_crc_checker.sv - scoreboard testbench for can_crc_checker
module tb_can_crc_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [6:0]  data_len;
    logic        bit_valid;
    logic        rx_bit;
    logic        abort;
    logic        busy;
    logic        crc_ok;
    logic        crc_err;
    logic        form_err;
    logic        stuff_err;
    logic [14:0] calc_crc;
    logic [14:0] rx_crc;

    can_crc_checker dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .data_len   (data_len),
        .bit_valid  (bit_valid),
        .rx_bit     (rx_bit),
        .abort      (abort),
        .busy       (busy),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .form_err   (form_err),
        .stuff_err  (stuff_err),
        .calc_crc   (calc_crc),
        .rx_crc     (rx_crc)
    );

    always #5 clk = ~clk;

    // flags = {crc_ok, crc_err, form_err, stuff_err}
    typedef struct packed {
        logic [3:0]  flags;
        logic [14:0] calc;
        logic [14:0] rx;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          run_len;
    logic        run_bit;
    logic [14:0] last_calc;
    logic [14:0] last_rx;

    function automatic logic [14:0] crc_model(input logic [82:0] v, input int n);
        logic [14:0] c;
        logic        nx;
        c = 15'd0;
        for (int i = n - 1; i >= 0; i--) begin
            nx = v[i] ^ c[14];
            c  = {c[13:0], 1'b0} ^ (nx ? 15'h4599 : 15'h0000);
        end
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic b);
        bit_valid = 1'b1;
        rx_bit    = b;
        tick();
        bit_valid = 1'b0;
        rx_bit    = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // Payload bit; in the stuffing build a complement bit is inserted after
    // five equal bits, exactly as a CAN transmitter would.
    task automatic put_bit(input logic b);
`ifdef CAN_CRC_CHK_STUFF_EN
        if (run_len == 5) begin
            send_raw(~run_bit);
            run_len = 1;
            run_bit = ~run_bit;
        end
        if (run_len != 0 && b == run_bit) run_len++;
        else begin
            run_len = 1;
            run_bit = b;
        end
`endif
        send_raw(b);
    endtask

    task automatic do_start(input int n, input logic with_bit);
        frame_start = 1'b1;
        data_len    = 7'(n);
        bit_valid   = with_bit;
        rx_bit      = 1'b1;
        tick();
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        run_len     = 0;
    endtask

    task automatic send_frame(input logic [82:0] v, input int n, input logic [14:0] rxc,
                              input logic delim, input logic with_bit);
        exp_t        e;
        logic [14:0] c;
        c = crc_model(v, n);
        do_start(n, with_bit);
        for (int i = n - 1; i >= 0; i--) put_bit(v[i]);
        for (int i = 14; i >= 0; i--) put_bit(rxc[i]);
        e.flags   = {c == rxc, c != rxc, ~delim, 1'b0};
        e.calc    = c;
        e.rx      = rxc;
        last_calc = c;
        last_rx   = rxc;
        q.push_back(e);
        send_raw(delim);
    endtask

    // Scoreboard consumer: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && (crc_ok || crc_err || form_err || stuff_err)) begin
            exp_t e;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got flags %b, required none", {crc_ok, crc_err, form_err, stuff_err});
            end else begin
                e = q.pop_front();
                if ({crc_ok, crc_err, form_err, stuff_err} !== e.flags) begin
                    n_bad++;
                    $display("FAIL verdict_flags: got %b, required %b", {crc_ok, crc_err, form_err, stuff_err}, e.flags);
                end
                if (!e.flags[0] && (calc_crc !== e.calc || rx_crc !== e.rx)) begin
                    n_bad++;
                    $display("FAIL verdict_crcs: got calc=%h rx=%h, required calc=%h rx=%h", calc_crc, rx_crc, e.calc, e.rx);
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0; frame_start = 1'b0; data_len = 7'd0; bit_valid = 1'b0; rx_bit = 1'b0; abort = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, crc_ok, crc_err, form_err, stuff_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b, required 00000", {busy, crc_ok, crc_err, form_err, stuff_err});
        end
        n_cmp++;
        if (calc_crc !== 15'd0 || rx_crc !== 15'd0) begin
            n_bad++; $display("FAIL reset_crcs: got calc=%h rx=%h, required 0", calc_crc, rx_crc);
        end
        rst = 1'b1;
        tick();
        // asynchronous reset in mid-frame
        do_start(8, 1'b0);
        send_raw(1'b1); send_raw(1'b1);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || calc_crc !== 15'd0) begin
            n_bad++; $display("FAIL async_reset: got busy=%b calc=%h, required 0/0", busy, calc_crc);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_good_frame;
        send_frame(83'h5A, 8, 15'h64FE, 1'b1, 1'b0);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL good_timeout: pending %0d, required 0", q.size()); q.delete(); end
        n_cmp++;
        if (calc_crc !== 15'h64FE || rx_crc !== 15'h64FE) begin
            n_bad++; $display("FAIL good_crcs: got calc=%h rx=%h, required 64fe/64fe", calc_crc, rx_crc);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy: got %b, required 0", busy); end
    endtask

    task automatic test_crc_mismatch;
        send_frame(83'h5A, 8, 15'h64FF, 1'b1, 1'b0);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL mismatch_timeout: pending %0d, required 0", q.size()); q.delete(); end
        n_cmp++;
        if (rx_crc !== 15'h64FF) begin n_bad++; $display("FAIL mismatch_rx: got %h, required 64ff", rx_crc); end
    endtask

    task automatic test_form_err;
        send_frame(83'h5A, 8, 15'h64FE, 1'b0, 1'b0);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL form_timeout: pending %0d, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_abort;
        do_start(8, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_start: got %b, required 1", busy); end
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b, required 0", busy); end
        send_raw(1'b1); send_raw(1'b0); send_raw(1'b1);
        n_cmp++;
        if (busy !== 1'b0 || calc_crc !== crc_model(83'h5, 4) || rx_crc !== 15'd0) begin
            n_bad++; $display("FAIL abort_hold: got busy=%b calc=%h rx=%h, required 0/%h/0", busy, calc_crc, rx_crc, crc_model(83'h5, 4));
        end
        // abort wins over a delimiter bit in the same cycle
        do_start(8, 1'b0);
        for (int i = 7; i >= 0; i--) put_bit(logic'(8'h5A >> i));
        for (int i = 14; i >= 0; i--) put_bit(logic'(15'h64FE >> i));
        abort = 1'b1; bit_valid = 1'b1; rx_bit = 1'b1;
        tick();
        abort = 1'b0; bit_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_delim_busy: got %b, required 0", busy); end
        send_frame(83'h5A, 8, 15'h64FE, 1'b1, 1'b0);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL abort_next_timeout: pending %0d, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_restart;
        do_start(8, 1'b0);
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
        send_frame(83'h3C1, 11, crc_model(83'h3C1, 11), 1'b1, 1'b0);
        // a bit in the frame_start cycle is not the first data bit
        send_frame(83'h5A, 8, 15'h64FE, 1'b1, 1'b1);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL restart_timeout: pending %0d, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_bad_len;
        int lens[3] = '{0, 84, 127};
        foreach (lens[j]) begin
            do_start(lens[j], 1'b0);
            send_raw(1'b0); send_raw(1'b1);
            n_cmp++;
            if (busy !== 1'b0 || calc_crc !== last_calc || rx_crc !== last_rx) begin
                n_bad++; $display("FAIL bad_len_%0d: got busy=%b calc=%h rx=%h, required 0/%h/%h", lens[j], busy, calc_crc, rx_crc, last_calc, last_rx);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [82:0] v;
        logic [14:0] c;
        int          n;
        for (int f = 0; f < 8; f++) begin
            n = (f == 0) ? 1 : (f == 1) ? 83 : int'($urandom_range(1, 83));
            v = {$urandom, $urandom, $urandom};
            c = crc_model(v, n);
            if (f % 3 == 2) c = c ^ (15'd1 << $urandom_range(0, 14));
            send_frame(v, n, c, (f % 4 != 3), 1'b0);
        end
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL b2b_timeout: pending %0d, required 0", q.size()); q.delete(); end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b, required 0", busy); end
    endtask

`ifdef CAN_CRC_CHK_STUFF_EN
    task automatic test_stuff;
        exp_t e;
        send_frame(83'h07, 8, crc_model(83'h07, 8), 1'b1, 1'b0);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL stuff_timeout: pending %0d, required 0", q.size()); q.delete(); end
        n_cmp++;
        if (calc_crc !== crc_model(83'h07, 8)) begin
            n_bad++; $display("FAIL stuff_calc: got %h, required %h", calc_crc, crc_model(83'h07, 8));
        end
        do_start(8, 1'b0);
        e.flags = 4'b0001; e.calc = 15'd0; e.rx = 15'd0;
        q.push_back(e);
        repeat (6) send_raw(1'b0);
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL stuff_err_timeout: pending %0d, required 0", q.size()); q.delete(); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL stuff_err_busy: got %b, required 0", busy); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        last_calc = 15'd0;
        last_rx   = 15'd0;
        run_len   = 0;
        run_bit   = 1'b0;
        test_reset();
        test_good_frame();
        test_crc_mismatch();
        test_form_err();
        test_abort();
        test_restart();
        test_bad_len();
        test_back_to_back();
`ifdef CAN_CRC_CHK_STUFF_EN
        test_stuff();
`endif
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
